// File: rtl/picobello_mcast_dst_iter.sv
// Multicast destination expander: takes one multicast request (address plus
// X/Y field mask) and emits every covered unicast destination, one per cycle.
// Y sub-values vary fastest, X slowest; each field walks its submask in
// ascending order.
module picobello_mcast_dst_iter #(
    parameter int unsigned AddrWidth  = 48,
    parameter int unsigned YOffset    = 18,
    parameter int unsigned YLen       = 2,
    parameter int unsigned XOffset    = 20,
    parameter int unsigned XLen       = 2,
    parameter int unsigned XBase      = 0,
    parameter int unsigned YBase      = 0,
    parameter int unsigned MaxX       = 3,
    parameter int unsigned MaxY       = 3,
    parameter int unsigned CoordWidth = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [AddrWidth-1:0]  req_addr_i,
    input  logic [AddrWidth-1:0]  req_mask_i,
    output logic                  dst_valid_o,
    input  logic                  dst_ready_i,
    output logic [AddrWidth-1:0]  dst_addr_o,
    output logic [CoordWidth-1:0] dst_x_o,
    output logic [CoordWidth-1:0] dst_y_o,
    output logic                  dst_oor_o,
    output logic                  dst_last_o,
    output logic                  busy_o
);

    typedef enum logic {IDLE, ITER} state_t;

    state_t                r_state;
    logic [AddrWidth-1:0]  r_addr;
    logic [XLen-1:0]       r_mx;
    logic [YLen-1:0]       r_my;
    logic [XLen-1:0]       r_sx;
    logic [YLen-1:0]       r_sy;
    logic                  r_valid;
    logic [AddrWidth-1:0]  r_dst_addr;
    logic [CoordWidth-1:0] r_dst_x;
    logic [CoordWidth-1:0] r_dst_y;
    logic                  r_oor;
    logic                  r_last;

    logic [XLen-1:0]       w_nx_sum, w_nsx;
    logic [YLen-1:0]       w_ny_sum, w_nsy;
    logic [AddrWidth-1:0]  w_src_addr, w_addr;
    logic [XLen-1:0]       w_mx, w_sx, w_fx;
    logic [YLen-1:0]       w_my, w_sy, w_fy;
    logic [CoordWidth-1:0] w_x, w_y;
    logic                  w_oor, w_last;
    logic                  w_hs_req, w_hs_dst;
    logic                  w_unused_mask;

    // Bits outside the X/Y fields of the mask carry no meaning here.
    assign w_unused_mask = ^req_mask_i;

    assign w_hs_req = req_valid_i && (r_state == IDLE);
    assign w_hs_dst = r_valid && dst_ready_i;

    // Submask successor for each field, in field width.
    always_comb begin
        w_nx_sum = (r_sx | ~r_mx) + XLen'(1);
        w_nsx    = w_nx_sum & r_mx;
        w_ny_sum = (r_sy | ~r_my) + YLen'(1);
        w_nsy    = w_ny_sum & r_my;
    end

    // Next beat: the first beat of a new request in IDLE, else the successor.
    always_comb begin
        w_src_addr = r_addr;
        w_mx       = r_mx;
        w_my       = r_my;
        w_sx       = r_sx;
        w_sy       = r_sy;
        if (r_state == IDLE) begin
            w_src_addr = req_addr_i;
            w_mx       = req_mask_i[XOffset+:XLen];
            w_my       = req_mask_i[YOffset+:YLen];
            w_sx       = '0;
            w_sy       = '0;
        end else if (r_sy != r_my) begin
            w_sy = w_nsy;
        end else begin
            w_sx = w_nsx;
            w_sy = '0;
        end
        w_fx   = (w_src_addr[XOffset+:XLen] & ~w_mx) | w_sx;
        w_fy   = (w_src_addr[YOffset+:YLen] & ~w_my) | w_sy;
        w_addr = w_src_addr;
        w_addr[XOffset+:XLen] = w_fx;
        w_addr[YOffset+:YLen] = w_fy;
        w_x    = CoordWidth'(w_fx) + CoordWidth'(XBase);
        w_y    = CoordWidth'(w_fy) + CoordWidth'(YBase);
        w_oor  = (32'(w_x) > MaxX) || (32'(w_y) > MaxY);
        w_last = (w_sx == w_mx) && (w_sy == w_my);
    end

    // Control FSM with registered destination outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_mx       <= '0;
            r_my       <= '0;
            r_sx       <= '0;
            r_sy       <= '0;
            r_valid    <= 1'b0;
            r_dst_addr <= '0;
            r_dst_x    <= '0;
            r_dst_y    <= '0;
            r_oor      <= 1'b0;
            r_last     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_hs_req) begin
                        r_addr     <= req_addr_i;
                        r_mx       <= w_mx;
                        r_my       <= w_my;
                        r_sx       <= '0;
                        r_sy       <= '0;
                        r_valid    <= 1'b1;
                        r_dst_addr <= w_addr;
                        r_dst_x    <= w_x;
                        r_dst_y    <= w_y;
                        r_oor      <= w_oor;
                        r_last     <= w_last;
                        r_state    <= ITER;
                    end
                end
                ITER: begin
                    if (w_hs_dst) begin
                        if (r_last) begin
                            r_valid    <= 1'b0;
                            r_dst_addr <= '0;
                            r_dst_x    <= '0;
                            r_dst_y    <= '0;
                            r_oor      <= 1'b0;
                            r_last     <= 1'b0;
                            r_state    <= IDLE;
                        end else begin
                            r_sx       <= w_sx;
                            r_sy       <= w_sy;
                            r_dst_addr <= w_addr;
                            r_dst_x    <= w_x;
                            r_dst_y    <= w_y;
                            r_oor      <= w_oor;
                            r_last     <= w_last;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready_o = (r_state == IDLE);
    assign busy_o      = (r_state == ITER);
    assign dst_valid_o = r_valid;
    assign dst_addr_o  = r_dst_addr;
    assign dst_x_o     = r_dst_x;
    assign dst_y_o     = r_dst_y;
    assign dst_oor_o   = r_oor;
    assign dst_last_o  = r_last;

endmodule

// File: tb/tb_picobello_mcast_dst_iter.sv
// Scoreboard bench for picobello_mcast_dst_iter. A second instance with
// MaxX=2 shares all inputs so its out-of-range flag can be checked per beat.
module tb_picobello_mcast_dst_iter;

    logic        clk;
    logic        rst_ni;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [47:0] req_addr_i;
    logic [47:0] req_mask_i;
    logic        dst_valid_o;
    logic        dst_ready_i;
    logic [47:0] dst_addr_o;
    logic [3:0]  dst_x_o;
    logic [3:0]  dst_y_o;
    logic        dst_oor_o;
    logic        dst_last_o;
    logic        busy_o;

    logic        u2_req_ready;
    logic        u2_dst_valid;
    logic [47:0] u2_dst_addr;
    logic [3:0]  u2_dst_x;
    logic [3:0]  u2_dst_y;
    logic        u2_dst_oor;
    logic        u2_dst_last;
    logic        u2_busy;

    picobello_mcast_dst_iter dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_addr_i  (req_addr_i),
        .req_mask_i  (req_mask_i),
        .dst_valid_o (dst_valid_o),
        .dst_ready_i (dst_ready_i),
        .dst_addr_o  (dst_addr_o),
        .dst_x_o     (dst_x_o),
        .dst_y_o     (dst_y_o),
        .dst_oor_o   (dst_oor_o),
        .dst_last_o  (dst_last_o),
        .busy_o      (busy_o)
    );

    picobello_mcast_dst_iter #(.MaxX(2)) dut_maxx2 (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid_i),
        .req_ready_o (u2_req_ready),
        .req_addr_i  (req_addr_i),
        .req_mask_i  (req_mask_i),
        .dst_valid_o (u2_dst_valid),
        .dst_ready_i (dst_ready_i),
        .dst_addr_o  (u2_dst_addr),
        .dst_x_o     (u2_dst_x),
        .dst_y_o     (u2_dst_y),
        .dst_oor_o   (u2_dst_oor),
        .dst_last_o  (u2_dst_last),
        .busy_o      (u2_busy)
    );

    typedef struct packed {
        logic [47:0] addr;
        logic [3:0]  x;
        logic [3:0]  y;
        logic        oor;
        logic        oor2;
        logic        last;
    } beat_t;

    beat_t q[$];
    int    n_chk  = 0;
    int    n_pass = 0;
    int    n_pop  = 0;
    logic  bp_en  = 1'b0;
    logic [7:0] lfsr = 8'hA5;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [47:0] ea(input logic [47:0] b, input logic [3:0] x, input logic [3:0] y);
        ea = {b[47:22], x[1:0], y[1:0], b[17:0]};
    endfunction

    task automatic push(input logic [47:0] b, input logic [3:0] x, input logic [3:0] y,
                        input logic last, input logic oor2);
        beat_t e;
        e.addr = ea(b, x, y);
        e.x    = x;
        e.y    = y;
        e.oor  = 1'b0;
        e.oor2 = oor2;
        e.last = last;
        q.push_back(e);
    endtask

    // Downstream ready: always high, or LFSR-driven when backpressure is on.
    initial begin
        dst_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            dst_ready_i = bp_en ? lfsr[0] : 1'b1;
        end
    end

    // Monitor: pops on each destination handshake and checks held beats.
    initial begin
        logic  have_prev;
        logic [62:0] prev;
        logic [62:0] cur;
        beat_t act;
        beat_t e;
        have_prev = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            if (!rst_ni) begin
                have_prev = 1'b0;
            end else begin
                act = '{dst_addr_o, dst_x_o, dst_y_o, dst_oor_o, u2_dst_oor, dst_last_o};
                cur = {act, dst_valid_o, busy_o};
                if (have_prev) chk("hold_stable", 64'(cur), 64'(prev));
                have_prev = dst_valid_o && !dst_ready_i;
                prev = cur;
                if (dst_valid_o && dst_ready_i) begin
                    if (q.size() == 0) begin
                        chk("unexpected_beat", 64'(act), 64'(0));
                    end else begin
                        e = q.pop_front();
                        chk("beat", 64'({act, busy_o}), 64'({e, 1'b1}));
                    end
                    n_pop++;
                end
            end
        end
    end

    task automatic send(input logic [47:0] a, input logic [47:0] m, output int w);
        req_addr_i  = a;
        req_mask_i  = m;
        req_valid_i = 1'b1;
        w = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (req_ready_o) break;
            w++;
        end
        chk("req_accept", 64'(w < 100), 64'(1));
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (q.size() == 0) break;
            @(negedge clk);
        end
        chk("drain", 64'(q.size()), 64'(0));
        @(posedge clk);
        #1;
        chk("ready_after_last", 64'({req_ready_o, dst_valid_o, busy_o}), 64'(3'b100));
    endtask

    task automatic push_case2();
        for (int x = 0; x < 4; x++)
            push(48'h0000_0004_0000, 4'(x), 4'd1, x == 3, x == 3);
    endtask

    task automatic push_case3();
        for (int x = 1; x < 4; x += 2)
            for (int y = 0; y < 4; y++)
                push(48'h1234_5610_1234, 4'(x), 4'(y), (x == 3) && (y == 3), x == 3);
    endtask

    initial begin
        int w;
        rst_ni      = 1'b0;
        req_valid_i = 1'b0;
        req_addr_i  = '0;
        req_mask_i  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state",
            64'({req_ready_o, dst_valid_o, busy_o, dst_last_o, dst_oor_o, dst_x_o, dst_y_o}),
            64'({3'b100, 2'b00, 8'h00}));
        chk("reset_addr", 64'(dst_addr_o), 64'(0));
        rst_ni = 1'b1;
        @(posedge clk);
        #1;

        // Unicast
        push(48'h0000_0028_0000, 4'd2, 4'd2, 1'b1, 1'b0);
        send(48'h0000_0028_0000, 48'h0, w);
        drain(50);

        // X broadcast (also the out-of-range case for the MaxX=2 instance)
        push_case2();
        send(48'h0000_0004_0000, 48'h0000_0030_0000, w);
        drain(50);

        // Sparse 2D fan-out; mask bits outside the fields must be ignored
        push_case3();
        send(48'h1234_5610_1234, 48'h8000_002C_0001, w);
        drain(50);

        // Same request under backpressure
        bp_en = 1'b1;
        push_case3();
        send(48'h1234_5610_1234, 48'h8000_002C_0001, w);
        drain(400);
        bp_en = 1'b0;
        @(posedge clk);
        #1;

        // Second request held during expansion: accepted right after last beat
        push_case2();
        send(48'h0000_0004_0000, 48'h0000_0030_0000, w);
        push(48'h0000_0028_0000, 4'd2, 4'd2, 1'b1, 1'b0);
        send(48'h0000_0028_0000, 48'h0, w);
        chk("held_req_wait", 64'(w), 64'(4));
        drain(50);

        // Reset during beat 2
        push_case2();
        begin
            int start;
            start = n_pop;
            send(48'h0000_0004_0000, 48'h0000_0030_0000, w);
            for (int i = 0; i < 50; i++) begin
                if (n_pop != start) break;
                @(negedge clk);
            end
            chk("first_beat_seen", 64'(n_pop - start), 64'(1));
        end
        @(posedge clk);
        #1;
        chk("beat2_present", 64'({dst_valid_o, dst_x_o}), 64'({1'b1, 4'd1}));
        rst_ni = 1'b0;
        #1;
        chk("async_reset_out",
            64'({req_ready_o, dst_valid_o, busy_o, dst_last_o, dst_x_o, dst_y_o}),
            64'({3'b100, 1'b0, 8'h00}));
        chk("async_reset_addr", 64'(dst_addr_o), 64'(0));
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_ni = 1'b1;
        @(negedge clk);
        chk("after_reset_idle", 64'({req_ready_o, dst_valid_o, busy_o}), 64'(3'b100));
        @(posedge clk);
        #1;

        // Recovery after reset
        push(48'h0000_0028_0000, 4'd2, 4'd2, 1'b1, 1'b0);
        send(48'h0000_0028_0000, 48'h0, w);
        drain(50);
        repeat (3) @(negedge clk);
        chk("queue_empty_end", 64'(q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
